bit_map_gen: RTL and testbench
==============================

Name: bit_map_gen

Overview:
- Parametrised successor of the 16-bit VGA bit-map renderer.
- Draws DATA_W bits as a row of boxes split into groups of GROUP bits, MSB leftmost, inside a row/column window.
- Tracks position with run-length counters and a small FSM driven by a pixel strobe; it uses no absolute column comparators.
- Adds a frame-synchronous shadow latch (no tearing) and a changed-bit highlight output. Sits between the VGA timing generator and the colour mux.

Parameters:
- DATA_W, 16, number of displayed bits; must be a multiple of GROUP.
- GROUP, 4, bits per group.
- LEFT, 55, first box column (columns 0..LEFT-1 are margin).
- BOX_W, 34, box width in pixels.
- BOX_GAP, 5, pixels between boxes inside a group.
- GROUP_GAP, 29, pixels between groups.
- ROW_TOP, 0, first drawn row.
- ROW_H, 480, number of drawn rows.
- CW, 11, width of the internal column/row counters.

Ports:
- clk  in  1  pixel-domain clock.
- reset  in  1  asynchronous, active-high.
- pix_en  in  1  one pixel per cycle while high.
- line_start  in  1  this cycle is column 0 of a line.
- frame_start  in  1  start of frame: row counter to 0, shadow latch loads.
- data  in  DATA_W  live bit vector.
- color  out  1  box bit value (fg select).
- bc  out  1  background select.
- hl  out  1  box's bit changed at the last frame latch.

Behaviour:
- Reset (async) values: color=1, bc=0, hl=0. Shadow=0, prev=0, row=0, FSM=MARGIN, all counters 0.
- Shadow: on a frame_start cycle, prev<=shadow and shadow<=data. The new shadow takes effect from the next cycle; a pixel in the same cycle uses the old shadow.
- Row counter:
  - frame_start sets row to 0; this has priority over line_start.
  - Otherwise line_start increments row, saturating at 2^CW-1.
  - in_rows = (row >= ROW_TOP) && (row < ROW_TOP+ROW_H).
- Column FSM advances only on pix_en. line_start forces state MARGIN with run=0 and bit=DATA_W-1, and that same pixel is column 0.
- FSM states and transitions:
  - MARGIN: run counts 0..LEFT-1, then BOX. If LEFT=0, go straight to BOX at column 0.
  - BOX: run counts 0..BOX_W-1. At end: if bit==0, go to DONE. Else if bit%GROUP==0, go to GGAP. Else go to GAP. bit decrements on leaving BOX.
  - GAP: BOX_GAP pixels, then BOX. GGAP: GROUP_GAP pixels, then BOX. A zero-length gap goes straight to BOX.
  - DONE: hold until line_start.
- Outputs are registered, 1-cycle latency from the pix_en cycle:
  - In BOX with in_rows: color=shadow[bit], bc=0, hl=shadow[bit]^prev[bit].
  - Otherwise: color=0, bc=1, hl=0.
- pix_en low: FSM and outputs hold.
- With defaults, boxes occupy columns 55-88, 94-127, 133-166, 172-205, 235-268 … 712-745. This matches the 16-bit legacy layout exactly.
- Reset mid-line: outputs return to reset values immediately. Drawing resumes correctly at the next line_start.

Test Plan:
- Defaults, data=16'hA5C3, frame_start, then one line of 800 pix_en starting with line_start. Required per-column outputs:
  - col 55-88: color=1, bc=0 (bit15=1).
  - col 94-127: color=0, bc=0.
  - col 89-93 and col 206-234: bc=1.
  - col 712-745: color=1 (bit0).
  - col 746+: bc=1.
  - All outputs appear 1 cycle after the pixel's cycle.
- Change data to 16'h0000 mid-line -> no change until the next frame_start. The following frame shows all boxes color=0, and hl=1 on bits 15,13,10,8,7,6,1,0.
- DATA_W=8, GROUP=2, LEFT=0, BOX_W=4, BOX_GAP=1, GROUP_GAP=3, data=8'h81 -> boxes at cols 0-3, 5-8, 12-15, 17-20, 24-27, 29-32, 36-39, 41-44. color=1 only on cols 0-3 and 41-44.
- ROW_TOP=10, ROW_H=2 -> rows 10 and 11 draw boxes; rows 9 and 12 give bc=1 across the whole line.
- pix_en toggling 50% duty -> same column map as the continuous case, measured in pix_en counts; outputs hold when pix_en=0.
- Assert reset at column 100 -> same cycle color=1, bc=0, hl=0. After release and a new frame_start/line_start, correct output resumes.

Source files
------------

// File: rtl/bit_map_gen.sv
// Bit-map renderer: draws DATA_W shadowed bits as grouped boxes
// using run-length column tracking driven by a pixel strobe.
module bit_map_gen #(
  parameter int DATA_W    = 16,
  parameter int GROUP     = 4,
  parameter int LEFT      = 55,
  parameter int BOX_W     = 34,
  parameter int BOX_GAP   = 5,
  parameter int GROUP_GAP = 29,
  parameter int ROW_TOP   = 0,
  parameter int ROW_H     = 480,
  parameter int CW        = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              line_start,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] data,
  output logic              color,
  output logic              bc,
  output logic              hl
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    MARGIN, BOX, GAP, GGAP, DONE
  } state_t;

  localparam state_t START = (LEFT == 0) ? BOX : MARGIN;
  localparam logic [BW-1:0] TOP = BW'(DATA_W - 1);
  localparam logic [CW:0] L_END  = (CW+1)'(LEFT);
  localparam logic [CW:0] B_END  = (CW+1)'(BOX_W);
  localparam logic [CW:0] G_END  = (CW+1)'(BOX_GAP);
  localparam logic [CW:0] GG_END = (CW+1)'(GROUP_GAP);
  localparam logic [CW:0] ROW_LO = (CW+1)'(ROW_TOP);
  localparam logic [CW:0] ROW_HI = (CW+1)'(ROW_TOP + ROW_H);

  state_t state, state_nx, cur_state;
  logic [CW-1:0] run, run_nx, cur_run;
  logic [CW-1:0] row, row_cur;
  logic [CW:0] run_p1;
  logic [BW-1:0] bit_idx, bit_nx, cur_bit;
  logic [DATA_W-1:0] shadow, prev;
  logic in_rows;

  // Effective position of this pixel: line_start makes it column 0
  always_comb begin
    cur_state = state;
    cur_run   = run;
    cur_bit   = bit_idx;
    if (line_start) begin
      cur_state = START;
      cur_run   = '0;
      cur_bit   = TOP;
    end
  end

  // Row of this pixel and vertical window test
  always_comb begin
    row_cur = row;
    if (frame_start) begin
      row_cur = '0;
    end else if (line_start && (row != '1)) begin
      row_cur = row + 1'b1;
    end
    in_rows = ({1'b0, row_cur} >= ROW_LO) &&
              ({1'b0, row_cur} < ROW_HI);
  end

  // Run-length column FSM: next position after this pixel
  always_comb begin
    state_nx = cur_state;
    run_nx   = cur_run;
    bit_nx   = cur_bit;
    run_p1   = {1'b0, cur_run} + 1'b1;
    unique case (cur_state)
      MARGIN: begin
        if (run_p1 >= L_END) begin
          state_nx = BOX;
          run_nx   = '0;
        end else begin
          run_nx = cur_run + 1'b1;
        end
      end
      BOX: begin
        if (run_p1 >= B_END) begin
          run_nx = '0;
          if (cur_bit == '0) begin
            state_nx = DONE;
          end else begin
            bit_nx = cur_bit - 1'b1;
            if ((int'(cur_bit) % GROUP) == 0) begin
              state_nx = (GROUP_GAP == 0) ? BOX : GGAP;
            end else begin
              state_nx = (BOX_GAP == 0) ? BOX : GAP;
            end
          end
        end else begin
          run_nx = cur_run + 1'b1;
        end
      end
      GAP: begin
        if (run_p1 >= G_END) begin
          state_nx = BOX;
          run_nx   = '0;
        end else begin
          run_nx = cur_run + 1'b1;
        end
      end
      GGAP: begin
        if (run_p1 >= GG_END) begin
          state_nx = BOX;
          run_nx   = '0;
        end else begin
          run_nx = cur_run + 1'b1;
        end
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = DONE;
      end
    endcase
  end

  // Position, row and frame-synchronous shadow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MARGIN;
      run     <= '0;
      bit_idx <= '0;
      row     <= '0;
      shadow  <= '0;
      prev    <= '0;
    end else begin
      row <= row_cur;
      if (frame_start) begin
        prev   <= shadow;
        shadow <= data;
      end
      if (pix_en) begin
        state   <= state_nx;
        run     <= run_nx;
        bit_idx <= bit_nx;
      end else if (line_start) begin
        state   <= START;
        run     <= '0;
        bit_idx <= TOP;
      end
    end
  end

  // Registered pixel outputs, one cycle after the strobed pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color <= 1'b1;
      bc    <= 1'b0;
      hl    <= 1'b0;
    end else if (pix_en) begin
      if ((cur_state == BOX) && in_rows) begin
        color <= shadow[cur_bit];
        bc    <= 1'b0;
        hl    <= shadow[cur_bit] ^ prev[cur_bit];
      end else begin
        color <= 1'b0;
        bc    <= 1'b1;
        hl    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_map_gen.sv
// Directed bench for bit_map_gen: default layout, small layout,
// row window, strobe gaps, frame latch and mid-line reset.
module tb_bit_map_gen;

  logic clk = 1'b0;
  logic reset, pix_en, line_start, frame_start;
  logic [15:0] data16;
  logic [7:0]  data8;
  logic d_c, d_b, d_h;
  logic s_c, s_b, s_h;
  logic r_c, r_b, r_h;

  logic [2:0] drec [800];
  logic [2:0] srec [800];
  logic [2:0] rrec [800];
  logic [15:0] sh16, pv16;
  logic [7:0]  sh8, pv8;
  int row_tb;
  int n_assert = 0;
  int n_fail = 0;

  bit_map_gen u_def (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .line_start(line_start), .frame_start(frame_start),
    .data(data16), .color(d_c), .bc(d_b), .hl(d_h)
  );

  bit_map_gen #(
    .DATA_W(8), .GROUP(2), .LEFT(0), .BOX_W(4),
    .BOX_GAP(1), .GROUP_GAP(3)
  ) u_small (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .line_start(line_start), .frame_start(frame_start),
    .data(data8), .color(s_c), .bc(s_b), .hl(s_h)
  );

  bit_map_gen #(
    .ROW_TOP(10), .ROW_H(2)
  ) u_row (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .line_start(line_start), .frame_start(frame_start),
    .data(data16), .color(r_c), .bc(r_b), .hl(r_h)
  );

  always #5 clk = ~clk;

  function automatic int box_of(int col, int dw, int grp,
                                int left, int bw, int bg, int gg);
    for (int i = 0; i < dw; i++) begin
      int s;
      s = left + i * (bw + bg) + (i / grp) * (gg - bg);
      if (col >= s && col < s + bw) return dw - 1 - i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_def(int col);
    int b;
    b = box_of(col, 16, 4, 55, 34, 5, 29);
    if (b < 0 || row_tb >= 480) return 3'b010;
    return {sh16[b], 1'b0, sh16[b] ^ pv16[b]};
  endfunction

  function automatic logic [2:0] exp_row(int col);
    int b;
    b = box_of(col, 16, 4, 55, 34, 5, 29);
    if (b < 0 || row_tb < 10 || row_tb > 11) return 3'b010;
    return {sh16[b], 1'b0, sh16[b] ^ pv16[b]};
  endfunction

  function automatic logic [2:0] exp_small(int col);
    int b;
    b = box_of(col, 8, 2, 0, 4, 1, 3);
    if (b < 0 || row_tb >= 480) return 3'b010;
    return {sh8[b], 1'b0, sh8[b] ^ pv8[b]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ls, input logic pe);
    line_start = ls;
    pix_en = pe;
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step(1'b0, 1'b0);
    frame_start = 1'b0;
    pv16 = sh16;
    sh16 = data16;
    pv8 = sh8;
    sh8 = data8;
    row_tb = 0;
  endtask

  task automatic run_line(input int npix, input bit half,
                          input int chg_col);
    row_tb++;
    for (int col = 0; col < npix; col++) begin
      if (col == chg_col) data16 = 16'h0000;
      step(col == 0, 1'b1);
      drec[col] = {d_c, d_b, d_h};
      srec[col] = {s_c, s_b, s_h};
      rrec[col] = {r_c, r_b, r_h};
      if (half) begin
        step(1'b0, 1'b0);
        chk($sformatf("hold c%0d", col),
            {13'b0, d_c, d_b, d_h}, {13'b0, exp_def(col)});
      end
    end
    line_start = 1'b0;
    pix_en = 1'b0;
  endtask

  task automatic check_line(input int npix);
    for (int col = 0; col < npix; col++) begin
      chk($sformatf("def r%0d c%0d", row_tb, col),
          {13'b0, drec[col]}, {13'b0, exp_def(col)});
      chk($sformatf("small r%0d c%0d", row_tb, col),
          {13'b0, srec[col]}, {13'b0, exp_small(col)});
      chk($sformatf("row r%0d c%0d", row_tb, col),
          {13'b0, rrec[col]}, {13'b0, exp_row(col)});
    end
  endtask

  initial begin
    reset = 1'b1;
    pix_en = 1'b0;
    line_start = 1'b0;
    frame_start = 1'b0;
    data16 = 16'h0000;
    data8 = 8'h00;
    sh16 = '0; pv16 = '0; sh8 = '0; pv8 = '0;
    row_tb = 0;
    #12;
    chk("rst def", {13'b0, d_c, d_b, d_h}, 16'h4);
    chk("rst small", {13'b0, s_c, s_b, s_h}, 16'h4);
    chk("rst row", {13'b0, r_c, r_b, r_h}, 16'h4);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b0);

    data16 = 16'hA5C3;
    data8 = 8'h81;
    frame();
    run_line(800, 1'b0, -1);
    check_line(800);
    chk("c55 bit15", {13'b0, drec[55]}, 16'h5);
    chk("c88 bit15", {13'b0, drec[88]}, 16'h5);
    chk("c94 bit14", {13'b0, drec[94]}, 16'h0);
    chk("c89 gap", {13'b0, drec[89]}, 16'h2);
    chk("c206 ggap", {13'b0, drec[206]}, 16'h2);
    chk("c234 ggap", {13'b0, drec[234]}, 16'h2);
    chk("c712 bit0", {13'b0, drec[712]}, 16'h5);
    chk("c746 done", {13'b0, drec[746]}, 16'h2);
    chk("s c0", {13'b0, srec[0]}, 16'h5);
    chk("s c44", {13'b0, srec[44]}, 16'h5);
    chk("s c4 gap", {13'b0, srec[4]}, 16'h2);
    chk("s c5 bit6", {13'b0, srec[5]}, 16'h0);

    run_line(800, 1'b0, 300);
    check_line(800);
    chk("nolatch c712", {13'b0, drec[712]}, 16'h5);

    frame();
    run_line(800, 1'b0, -1);
    check_line(800);
    chk("hl bit15", {13'b0, drec[55]}, 16'h1);
    chk("hl bit14", {13'b0, drec[94]}, 16'h0);
    chk("hl bit0", {13'b0, drec[712]}, 16'h1);

    for (int r = 2; r <= 8; r++) run_line(10, 1'b0, -1);
    for (int r = 9; r <= 12; r++) begin
      run_line(800, 1'b0, -1);
      check_line(800);
    end
    chk("row12 c55", {13'b0, rrec[55]}, 16'h2);

    run_line(800, 1'b1, -1);
    check_line(800);

    run_line(100, 1'b0, -1);
    line_start = 1'b0;
    pix_en = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst def", {13'b0, d_c, d_b, d_h}, 16'h4);
    chk("midrst small", {13'b0, s_c, s_b, s_h}, 16'h4);
    chk("midrst row", {13'b0, r_c, r_b, r_h}, 16'h4);
    pix_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sh16 = '0; pv16 = '0; sh8 = '0; pv8 = '0;
    row_tb = 0;
    step(1'b0, 1'b0);
    data16 = 16'hA5C3;
    data8 = 8'h81;
    frame();
    run_line(800, 1'b0, -1);
    check_line(800);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
